chunked_not_equal_checker: RTL and testbench

- Multi-cycle, handshaked inequality checker for BUS_SIZE operands.
- Compares operands one CHUNK_SIZE slice per clock, LSB slice first.
- Reports whether the operands differ and the index of the first (lowest) differing slice.
- Serves the debug unit, which compares captured register/memory words against expected values without a wide single-cycle comparator on the critical path.

---
 rtl/chunked_not_equal_checker.sv | 125 ++++++++++++
 tb/tb_chunked_not_equal_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_not_equal_checker.sv
// Handshaked multi-cycle inequality checker: compares two BUS_SIZE operands one CHUNK_SIZE slice
// per clock, LSB slice first. Define CHUNKED_NE_EARLY_EXIT_EN to stop at the first mismatching slice.
module chunked_not_equal_checker #(
    parameter int BUS_SIZE   = 32,
    parameter int CHUNK_SIZE = 8,
    parameter int IDX_SIZE   = ((BUS_SIZE / CHUNK_SIZE) > 1) ? $clog2(BUS_SIZE / CHUNK_SIZE) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_start,
    input  logic [BUS_SIZE-1:0] in_a,
    input  logic [BUS_SIZE-1:0] in_b,
    output logic                out_ready,
    output logic                out_busy,
    output logic                out_done,
    output logic                out_is_not_equal,
    output logic [IDX_SIZE-1:0] out_diff_index
);

    localparam int N = BUS_SIZE / CHUNK_SIZE;
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(N - 1);

    if ((BUS_SIZE % CHUNK_SIZE) != 0 || N < 2) begin : g_bad_params
        $error("chunked_not_equal_checker: BUS_SIZE must be a multiple of CHUNK_SIZE with at least 2 slices");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [BUS_SIZE-1:0] a_q, b_q;
    logic [IDX_SIZE-1:0] slice_cnt;
    logic                slice_ne;
    logic                last_slice;

    // The operand copies shift right each compare cycle, so slice k always sits in the low bits.
    assign slice_ne   = (a_q[CHUNK_SIZE-1:0] != b_q[CHUNK_SIZE-1:0]);
    assign last_slice = (slice_cnt == LAST_IDX);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        out_ready  = 1'b0;
        out_busy   = 1'b0;
        out_done   = 1'b0;

        unique case (state)
            IDLE: begin
                out_ready = 1'b1;
                if (in_start) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                out_busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
`ifdef CHUNKED_NE_EARLY_EXIT_EN
                if (slice_ne) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                out_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the operand copies are plain flops, not a memory, so they are cleared by reset like the rest.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q              <= '0;
            b_q              <= '0;
            slice_cnt        <= '0;
            out_is_not_equal <= 1'b0;
            out_diff_index   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_start) begin
                        a_q              <= in_a;
                        b_q              <= in_b;
                        slice_cnt        <= '0;
                        out_is_not_equal <= 1'b0;
                        out_diff_index   <= '0;
                    end
                end
                COMPARE: begin
                    // Only the first (lowest) mismatch is recorded; later ones leave the index alone.
                    if (slice_ne && !out_is_not_equal) begin
                        out_is_not_equal <= 1'b1;
                        out_diff_index   <= slice_cnt;
                    end
                    a_q <= a_q >> CHUNK_SIZE;
                    b_q <= b_q >> CHUNK_SIZE;
                    if (!last_slice) begin
                        slice_cnt <= slice_cnt + IDX_SIZE'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_not_equal_checker.sv
// Directed bench for chunked_not_equal_checker: vector table for result/latency plus hand-written
// sequences for reset, ignored start and mid-compare abort. Honours CHUNKED_NE_EARLY_EXIT_EN.
module tb_chunked_not_equal_checker;

    localparam int N = 4;
`ifdef CHUNKED_NE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_start;
    logic [31:0] in_a, in_b;
    logic        out_ready, out_busy, out_done, out_is_not_equal;
    logic [1:0]  out_diff_index;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    chunked_not_equal_checker #(.BUS_SIZE(32), .CHUNK_SIZE(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_start         (in_start),
        .in_a             (in_a),
        .in_b             (in_b),
        .out_ready        (out_ready),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_is_not_equal (out_is_not_equal),
        .out_diff_index   (out_diff_index)
    );

    always #5 clk = ~clk;

    // out_done is a state decode, so sampling shortly after each edge counts every pulse once.
    always @(posedge clk) begin
        #2;
        if (out_done) done_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_ne;
        logic [1:0]  exp_idx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic ne, input logic [1:0] idx);
        if (EARLY && ne) return int'(idx) + 1;
        return N;
    endfunction

    // Called at a negedge in IDLE. Returns the edge count from the accepting edge to out_done.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, output int lat,
                           output logic ne, output logic [1:0] idx, output logic busy_seen);
        in_a = a;
        in_b = b;
        in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        in_a = ~a;
        in_b = b ^ 32'h5A5A_5A5A;
        busy_seen = out_busy && !out_ready && !out_done;
        lat = -1;
        ne = 1'b0;
        idx = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_done) begin
                lat = c;
                ne = out_is_not_equal;
                idx = out_diff_index;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   p0;
        logic ne;
        logic [1:0] idx;
        logic busy_seen;

        vecs[0] = '{"zero_eq",     32'h0000_0000, 32'h0000_0000, 1'b0, 2'd0};
        vecs[1] = '{"ones_eq",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd0};
        vecs[2] = '{"lsb_diff",    32'h0000_0001, 32'h0000_0000, 1'b1, 2'd0};
        vecs[3] = '{"msb_diff",    32'h8000_0000, 32'h0000_0000, 1'b1, 2'd3};
        vecs[4] = '{"first_of_two",32'h00FF_0000, 32'h00FE_0001, 1'b1, 2'd0};
        vecs[5] = '{"slice1_diff", 32'h0000_0100, 32'h0000_0000, 1'b1, 2'd1};
        vecs[6] = '{"slice2_diff", 32'h1234_5678, 32'h1200_5678, 1'b1, 2'd2};
        vecs[7] = '{"mixed_eq",    32'hAB00_CD01, 32'hAB00_CD01, 1'b0, 2'd0};

        reset = 1'b0;
        in_start = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(out_ready), 32'd1);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_ne", 32'(out_is_not_equal), 32'd0);
        check("rst_idx", 32'(out_diff_index), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            p0 = done_pulses;
            run_req(vecs[i].a, vecs[i].b, lat, ne, idx, busy_seen);
            check({vecs[i].name, "_busy"}, 32'(busy_seen), 32'd1);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_latency(vecs[i].exp_ne, vecs[i].exp_idx)));
            check({vecs[i].name, "_ne"}, 32'(ne), 32'(vecs[i].exp_ne));
            check({vecs[i].name, "_idx"}, 32'(idx), 32'(vecs[i].exp_idx));
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, "_ready_after"}, 32'(out_ready), 32'd1);
            check({vecs[i].name, "_hold_ne"}, 32'(out_is_not_equal), 32'(vecs[i].exp_ne));
            check({vecs[i].name, "_hold_idx"}, 32'(out_diff_index), 32'(vecs[i].exp_idx));
            check({vecs[i].name, "_pulses"}, 32'(done_pulses - p0), 32'd1);
        end

        // Start pulsed mid-compare with different operands must be ignored.
        p0 = done_pulses;
        in_a = 32'h8000_0000;
        in_b = 32'h0000_0000;
        in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h0000_0001;
        in_b = 32'h0000_0000;
        in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        lat = -1;
        for (int c = 3; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_done) begin
                lat = c;
                break;
            end
        end
        check("ign_lat", 32'(lat), 32'd4);
        check("ign_ne", 32'(out_is_not_equal), 32'd1);
        check("ign_idx", 32'(out_diff_index), 32'd3);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("ign_pulses", 32'(done_pulses - p0), 32'd1);
        check("ign_ready", 32'(out_ready), 32'd1);

        // Reset asserted at E2 of a mismatching compare aborts with cleared results.
        p0 = done_pulses;
        in_a = 32'h0000_0100;
        in_b = 32'h0000_0000;
        in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", 32'(out_ready), 32'd1);
        check("abort_busy", 32'(out_busy), 32'd0);
        check("abort_done", 32'(out_done), 32'd0);
        check("abort_ne", 32'(out_is_not_equal), 32'd0);
        check("abort_idx", 32'(out_diff_index), 32'd0);
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_no_pulse", 32'(done_pulses - p0), 32'd0);

        p0 = done_pulses;
        run_req(32'h0000_0100, 32'h0000_0000, lat, ne, idx, busy_seen);
        check("after_abort_lat", 32'(lat), 32'(exp_latency(1'b1, 2'd1)));
        check("after_abort_ne", 32'(ne), 32'd1);
        check("after_abort_idx", 32'(idx), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("after_abort_pulses", 32'(done_pulses - p0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
